// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the 4:1 data mux: grants one requester for bursts of up to MAX_BURST beats.
// Latency: gnt/sel/busy one edge after req is seen in IDLE; out_valid and y are combinational.
// Backpressure: out_ready low freezes the beat count and the grant, with no timeout.
module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q;
    logic [1:0]      sel_q;
    logic [3:0]      gnt_q;
    logic [CW-1:0]   cnt_q;

    logic [1:0]      pick_idx;
    logic [1:0]      cand;
    logic            found;
    logic            xfer;
    logic            last_beat;
    logic            release_gnt;

    // First set request bit, scanning upward from the priority pointer.
    always_comb begin
        pick_idx = ptr_q;
        cand     = ptr_q;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                pick_idx = cand;
                found    = 1'b1;
            end
        end
    end

    assign xfer        = (state_q == GRANT) && req[sel_q] && out_ready;
    assign last_beat   = xfer && (cnt_q == CW'(MAX_BURST - 1));
    assign release_gnt = (state_q == GRANT) && (!req[sel_q] || last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)       state_d = GRANT;
            GRANT:   if (release_gnt) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // A requester drop and a final-beat release coincide as a single release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 2'd0;
            sel_q <= 2'd0;
            gnt_q <= 4'b0000;
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (found) begin
                sel_q <= pick_idx;
                gnt_q <= 4'b0001 << pick_idx;
                cnt_q <= '0;
            end
        end else if (release_gnt) begin
            gnt_q <= 4'b0000;
            ptr_q <= sel_q + 2'd1;
        end else if (xfer) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_comb begin
        busy      = (state_q == GRANT);
        out_valid = (state_q == GRANT) && req[sel_q];
        gnt       = gnt_q;
        sel       = sel_q;
        case (sel_q)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a vector table plus hand-written multi-cycle sequences.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] dat [4];

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic check_outs(input int step, input logic [3:0] eg, input logic [1:0] es,
                              input logic ev, input logic eb);
        chk("gnt",       step, 32'(gnt),       32'(eg));
        chk("sel",       step, 32'(sel),       32'(es));
        chk("out_valid", step, 32'(out_valid), 32'(ev));
        chk("busy",      step, 32'(busy),      32'(eb));
        chk("y",         step, 32'(y),         32'(dat[es]));
    endtask

    // Drive inputs after the falling edge, check just after, then let the rising edge act.
    task automatic cyc(input int step, input logic r, input logic [3:0] rq, input logic rdy,
                       input logic [3:0] eg, input logic [1:0] es, input logic ev, input logic eb);
        @(negedge clk);
        rst       = r;
        req       = rq;
        out_ready = rdy;
        #1;
        check_outs(step, eg, es, ev, eb);
    endtask

    function automatic void add(input logic r, input logic [3:0] rq, input logic rdy,
                                input logic [3:0] eg, input logic [1:0] es, input logic ev, input logic eb);
        vec_t v;
        v.rst = r; v.req = rq; v.rdy = rdy; v.gnt = eg; v.sel = es; v.vld = ev; v.busy = eb;
        vecs.push_back(v);
    endfunction

    initial begin
        dat[0] = 8'h11; dat[1] = 8'h5A; dat[2] = 8'hC3; dat[3] = 8'hD4;
        a = dat[0]; b = dat[1]; c = dat[2]; d = dat[3];
        rst = 1'b1; req = 4'b0000; out_ready = 1'b1;

        // Reset, single requester b with full burst and re-grant, then an immediate drop.
        add(1, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0010, 1, 4'b0000, 2'd0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 4'b0010, 1, 4'b0010, 2'd1, 1, 1);
        add(0, 4'b0010, 1, 4'b0000, 2'd1, 0, 0);
        add(0, 4'b0000, 1, 4'b0010, 2'd1, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 2'd1, 0, 0);
        // All four requesting: owners 0,1,2,3,0, four beats each, one idle cycle between.
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 4; k++) add(0, 4'b1111, 1, 4'b0001 << o, 2'(o), 1, 1);
            add(0, 4'b1111, 1, 4'b0000, 2'(o), 0, 0);
        end
        add(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 1);

        foreach (vecs[i])
            cyc(i, vecs[i].rst, vecs[i].req, vecs[i].rdy, vecs[i].gnt, vecs[i].sel, vecs[i].vld, vecs[i].busy);

        // Backpressure on c: three stalled cycles, then exactly four beats.
        cyc(100, 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        cyc(101, 0, 4'b0100, 0, 4'b0000, 2'd0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(102 + k, 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 1);
        for (int k = 0; k < 4; k++) cyc(105 + k, 0, 4'b0100, 1, 4'b0100, 2'd2, 1, 1);
        cyc(109, 0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0);

        // Early drop by a after two beats; b wins next.
        cyc(200, 1, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
        cyc(201, 0, 4'b0001, 1, 4'b0000, 2'd0, 0, 0);
        cyc(202, 0, 4'b0001, 1, 4'b0001, 2'd0, 1, 1);
        cyc(203, 0, 4'b0001, 1, 4'b0001, 2'd0, 1, 1);
        cyc(204, 0, 4'b1110, 1, 4'b0001, 2'd0, 0, 1);
        cyc(205, 0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        cyc(206, 0, 4'b1111, 1, 4'b0010, 2'd1, 1, 1);

        // Asynchronous reset in the middle of d's second beat; arbitration restarts at a.
        cyc(300, 1, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
        cyc(301, 0, 4'b1000, 1, 4'b0000, 2'd0, 0, 0);
        cyc(302, 0, 4'b1000, 1, 4'b1000, 2'd3, 1, 1);
        cyc(303, 0, 4'b1000, 1, 4'b1000, 2'd3, 1, 1);
        #2 rst = 1'b1;
        #1 check_outs(304, 4'b0000, 2'd0, 0, 0);
        cyc(305, 1, 4'b1001, 1, 4'b0000, 2'd0, 0, 0);
        cyc(306, 0, 4'b1001, 1, 4'b0000, 2'd0, 0, 0);
        cyc(307, 0, 4'b1001, 1, 4'b0001, 2'd0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin controller that shares the 4:1 `mux` datapath (inputs `a`/`b`/`c`/`d`, select `sel`, output `y`) between four requesters, turning it into a time-multiplexed output channel with a valid/ready handshake. It arbitrates among request lines, drives `sel` and one-hot grants, and holds each grant for a bounded burst. It sits between the four source blocks and the single downstream consumer of `y`.

## Interface
- `WIDTH`, default 8: data width of `a`/`b`/`c`/`d` and `y`.
- `MAX_BURST`, default 4: maximum beats per grant; legal range is 1 or greater.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  4  request lines; bit 0 = a, 1 = b, 2 = c, 3 = d.
- `a`, `b`, `c`, `d`  in  WIDTH each  requester data.
- `gnt`  out  4  one-hot grant, registered; all zeros when no owner.
- `sel`  out  2  registered mux select; equals the index of the current/last owner.
- `y`  out  WIDTH  combinational mux of `a`/`b`/`c`/`d` by `sel`.
- `out_valid`  out  1  beat on `y` is valid.
- `out_ready`  in  1  downstream accepts the beat.
- `busy`  out  1  high in GRANT state.

## Operation
- Internal state: FSM {IDLE, GRANT}, 2-bit priority pointer `ptr`, beat counter of width clog2(MAX_BURST+1).
- Reset values: state IDLE, `gnt`=0000, `sel`=0, `ptr`=0, count=0, `out_valid`=0, `busy`=0. Because `sel`=0, `y`=`a`.
- IDLE:
  - `gnt`=0 and `out_valid`=0.
  - If any `req` bit is set at the edge, pick the first set bit scanning `ptr`, `ptr`+1, … (mod 4).
  - Register its index into `sel` and its one-hot into `gnt`, clear count, and go to GRANT.
  - If `req`=0, stay in IDLE and leave `sel` unchanged.
- GRANT:
  - `out_valid` = `req[sel]`, combinational.
  - A beat transfers when `out_valid` and `out_ready` are both high; count increments on each transfer.
- Release occurs at the edge when either condition holds:
  - `req[sel]`=0; or
  - a transfer occurs with count = MAX_BURST-1.
- On release: go to IDLE, clear `gnt`, set `ptr` = `sel`+1 mod 4 (wraps from 3 to 0). `sel` keeps its value.
- Turnaround: exactly one IDLE cycle, with `gnt`=0, separates consecutive grants, including a re-grant to the same requester.
- Requester contract: hold `req` and data stable while granted until the beat is accepted. Dropping `req` abandons the rest of the burst without error.
- Non-owner `req` changes during GRANT are ignored until the next IDLE.
- With MAX_BURST=1, every accepted beat releases the grant.
- `rst` asserted at any time, including mid-burst, forces all reset values immediately, without waiting for a clock edge. Arbitration after reset starts from `a`.

## Timing
- Arbitration latency: a `req` sampled at edge k in IDLE produces `gnt`/`sel`/`busy` after edge k. `out_valid` rises in that same cycle.
- Throughput: with `out_ready`=1 and `req` held, one beat per cycle for MAX_BURST cycles, then 1 idle cycle. This gives MAX_BURST/(MAX_BURST+1) channel utilisation.
- `out_valid` is combinational from `req[sel]`. A requester drop is visible on `out_valid` in the same cycle.
- `y` follows data inputs combinationally. It changes source only after an edge that updates `sel`.
- Backpressure: with `out_ready`=0, count, `gnt` and `sel` are frozen. There is no timeout.
- Simultaneous release condition and `req` drop on the final beat count as one release: the pointer advances once.

## Test plan
1. Reset: `rst`=1 with `a`=8'h11 → `gnt`=0000, `sel`=0, `out_valid`=0, `busy`=0, `y`=8'h11. Assert `rst` asynchronously mid-cycle → outputs clear before the next edge.
2. Single requester: `req`=0010, `b`=8'h5A, `out_ready`=1 → `gnt`=0010 and `sel`=1 one edge later, `y`=8'h5A, exactly 4 beats, then one cycle of `gnt`=0. Then `b` is re-granted.
3. All `req`=1111, `out_ready`=1 → `sel` sequence 0,1,2,3,0. Each owner gets 4 beats, separated by exactly one idle cycle.
4. Backpressure: grant `c`, hold `out_ready`=0 for 3 cycles → `gnt`=0100 held, count unchanged, `out_valid`=1. Then `out_ready`=1 → 4 beats exactly, then release.
5. Early drop: `a` granted, `req[0]` falls after 2 beats → `out_valid`=0 in the same cycle, `gnt`=0 next cycle. With `req`=1111 afterwards → `b` granted next.
6. Reset mid-burst: `d` owning during beat 2, pulse `rst` → immediate reset values. Then `req`=1001 → `a` granted first.
